// File: rtl/batch_stream_host_pkg.sv
// Shared types and count widths for the batch stream host.
package batch_stream_host_pkg;

    // Per-batch word index width (ss/ds) and batch index width (nb).
    localparam int unsigned CntW   = 12;
    localparam int unsigned BatchW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRecv,
        StDone
    } host_st_t;

endpackage

// File: rtl/batch_stream_host_fifo2.sv
// Two-entry FIFO with occupancy output; feeds the source stream so that
// src_valid/src_data stay stable while the core stalls.
module batch_stream_host_fifo2 #(
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_pop;
    logic          w_push;

    // A pop on an empty FIFO is dropped; a push into a full FIFO only lands
    // when a pop frees a slot in the same cycle.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/batch_stream_host.sv
// Host side of the batch controller streams: prefetches source words from the
// source RAM into the core, and writes the core's result words to the
// destination RAM, for nb+1 batches back to back.
module batch_stream_host
    import batch_stream_host_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [CntW-1:0]   i_ss,
    input  logic [CntW-1:0]   i_ds,
    input  logic [BatchW-1:0] i_nb,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_src_valid,
    output logic              o_src_last,
    output logic [DW-1:0]     o_src_data,
    input  logic              i_src_ready,
    input  logic              i_dst_valid,
    input  logic [DW-1:0]     i_dst_data,
    output logic              o_dst_ready,
    input  logic              i_dst_hold,
    output logic              o_sbuf_re,
    output logic [AW-1:0]     o_sbuf_addr,
    input  logic [DW-1:0]     i_sbuf_rdata,
    output logic              o_dbuf_we,
    output logic [AW-1:0]     o_dbuf_addr,
    output logic [DW-1:0]     o_dbuf_wdata
);

    host_st_t          r_state;
    host_st_t          w_state_nxt;
    logic [CntW-1:0]   r_ss;
    logic [CntW-1:0]   r_ds;
    logic [BatchW-1:0] r_nb;
    logic [BatchW-1:0] r_bc;
    logic [CntW:0]     r_src_iss;  // reads issued this batch, reaches ss+1
    logic [CntW-1:0]   r_src_acc;  // beats accepted this batch
    logic [CntW-1:0]   r_dst_cnt;
    logic [AW-1:0]     r_saddr;
    logic [AW-1:0]     r_daddr;
    logic              r_inflight; // RAM read issued last cycle, data lands now
    logic              r_err;

    logic [1:0]        w_fifo_cnt;
    logic [DW-1:0]     w_fifo_head;
    logic [2:0]        w_occ;
    logic              w_start_ok;
    logic              w_src_valid;
    logic              w_src_beat;
    logic              w_src_last;
    logic              w_sbuf_re;
    logic              w_dst_ready;
    logic              w_dst_beat;
    logic              w_dst_last;

    assign w_start_ok  = i_start && (r_state == StIdle);
    assign w_src_valid = (r_state == StSend) && (w_fifo_cnt != 2'd0);
    assign w_src_beat  = w_src_valid && i_src_ready;
    assign w_src_last  = w_src_valid && (r_src_acc == r_ss);
    assign w_dst_ready = (r_state == StRecv) && !i_dst_hold;
    assign w_dst_beat  = w_dst_ready && i_dst_valid;
    assign w_dst_last  = w_dst_beat && (r_dst_cnt == r_ds);

    // Occupancy counts the word leaving this cycle as already gone, which is
    // what keeps a continuously-ready core fed without bubbles.
    assign w_occ     = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_src_beat};
    assign w_sbuf_re = (r_state == StSend) && (w_occ < 3'd2) && (r_src_iss <= {1'b0, r_ss});

    batch_stream_host_fifo2 #(
        .DW (DW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_inflight),
        .i_wdata (i_sbuf_rdata),
        .i_pop   (w_src_beat),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_cnt)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one SEND/RECV pair per batch, then a single DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_start_ok) w_state_nxt = StSend;
            StSend: if (w_src_beat && w_src_last) w_state_nxt = StRecv;
            StRecv: if (w_dst_last) w_state_nxt = (r_bc == r_nb) ? StDone : StSend;
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Run parameters, per-batch counters and linear buffer addresses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ss       <= '0;
            r_ds       <= '0;
            r_nb       <= '0;
            r_bc       <= '0;
            r_src_iss  <= '0;
            r_src_acc  <= '0;
            r_dst_cnt  <= '0;
            r_saddr    <= '0;
            r_daddr    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_sbuf_re;
            if (w_start_ok) begin
                r_ss      <= i_ss;
                r_ds      <= i_ds;
                r_nb      <= i_nb;
                r_bc      <= '0;
                r_src_iss <= '0;
                r_src_acc <= '0;
                r_dst_cnt <= '0;
                r_saddr   <= '0;
                r_daddr   <= '0;
            end else begin
                if (w_sbuf_re) begin
                    r_saddr   <= r_saddr + AW'(1);
                    r_src_iss <= r_src_iss + (CntW + 1)'(1);
                end
                // All reads are issued before the last beat, so no clash with the increment.
                if (w_src_beat) begin
                    if (w_src_last) begin
                        r_src_acc <= '0;
                        r_src_iss <= '0;
                    end else begin
                        r_src_acc <= r_src_acc + CntW'(1);
                    end
                end
                if (w_dst_beat) begin
                    r_daddr <= r_daddr + AW'(1);
                    if (w_dst_last) begin
                        r_dst_cnt <= '0;
                        if (r_bc != r_nb) r_bc <= r_bc + BatchW'(1);
                    end else begin
                        r_dst_cnt <= r_dst_cnt + CntW'(1);
                    end
                end
            end
        end
    end

    // Sticky protocol error: a result word offered while not receiving.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (i_dst_valid && (r_state != StRecv)) begin
            r_err <= 1'b1;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end
    end

    assign o_busy       = (r_state != StIdle);
    assign o_done       = (r_state == StDone);
    assign o_err        = r_err;
    assign o_src_valid  = w_src_valid;
    assign o_src_last   = w_src_last;
    assign o_src_data   = w_src_valid ? w_fifo_head : '0;
    assign o_dst_ready  = w_dst_ready;
    assign o_sbuf_re    = w_sbuf_re;
    assign o_sbuf_addr  = r_saddr;
    assign o_dbuf_we    = w_dst_beat;
    assign o_dbuf_addr  = r_daddr;
    assign o_dbuf_wdata = w_dst_beat ? i_dst_data : '0;

endmodule
